// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: data width, register index width,
// write-back control field positions and the hardwired zero register.
package pipe_pkg;

  localparam int XLEN        = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  // A write-back commits only when RegWrite is set and the target is not r0.
  function automatic logic wb_commits(input logic [1:0] wb,
                                      input logic [REG_ADDR_W-1:0] dest);
    return wb[WB_REGWRITE] && (dest != ZERO_REG);
  endfunction

endpackage

// File: rtl/wb_regfile.sv
// Architectural register file: NREGS x XLEN, one write port, two
// combinational read ports, r0 hardwired to zero.
// Build option: WB_BYPASS_EN selects write-first read ports (a read of the
// register being written this cycle returns the new value); without it the
// read ports return the pre-edge array contents.
module wb_regfile #(
  parameter int NREGS = 32,
  parameter int XLEN  = pipe_pkg::XLEN
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             we,
  input  logic [pipe_pkg::REG_ADDR_W-1:0]  waddr,
  input  logic [XLEN-1:0]                  wdata,
  input  logic [pipe_pkg::REG_ADDR_W-1:0]  rs_addr,
  input  logic [pipe_pkg::REG_ADDR_W-1:0]  rt_addr,
  output logic [XLEN-1:0]                  rs_data,
  output logic [XLEN-1:0]                  rt_data
);

  import pipe_pkg::*;

  logic [XLEN-1:0] regs [NREGS];

  // Clear every register on reset; otherwise commit the write port.
  // Reset takes priority so a write presented in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != ZERO_REG)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read port A: r0 reads zero, optional write-through of the current commit.
  always_comb begin
    rs_data = '0;
    if (rs_addr != ZERO_REG) begin
      rs_data = regs[rs_addr];
`ifdef WB_BYPASS_EN
      if (we && (rs_addr == waddr)) begin
        rs_data = wdata;
      end
`endif
    end
  end

  // Read port B: same behaviour as port A.
  always_comb begin
    rt_data = '0;
    if (rt_addr != ZERO_REG) begin
      rt_data = regs[rt_addr];
`ifdef WB_BYPASS_EN
      if (we && (rt_addr == waddr)) begin
        rt_data = wdata;
      end
`endif
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: selects load data or ALU result, commits it into the
// register file, publishes the commit on the forwarding bus and counts
// retired register writes.
// Build option: WB_BYPASS_EN (passed through to wb_regfile) makes the decode
// read ports write-first.
module wb_stage #(
  parameter int NREGS = 32,
  parameter int XLEN  = pipe_pkg::XLEN
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [1:0]                       WB,
  input  logic [XLEN-1:0]                  WB_Address,
  input  logic [XLEN-1:0]                  WB_Data,
  input  logic [pipe_pkg::REG_ADDR_W-1:0]  Write_Register,
  input  logic [pipe_pkg::REG_ADDR_W-1:0]  rs_addr,
  input  logic [pipe_pkg::REG_ADDR_W-1:0]  rt_addr,
  output logic [XLEN-1:0]                  rs_data,
  output logic [XLEN-1:0]                  rt_data,
  output logic                             fwd_valid,
  output logic [pipe_pkg::REG_ADDR_W-1:0]  fwd_dest,
  output logic [XLEN-1:0]                  fwd_value,
  output logic [31:0]                      retire_count
);

  import pipe_pkg::*;

  logic [XLEN-1:0] wb_value;
  logic            we;

  // Result select and commit decision; writes to r0 are discarded here so
  // they neither forward nor count.
  always_comb begin
    wb_value = WB[WB_MEMTOREG] ? WB_Data : WB_Address;
    we       = wb_commits(WB, Write_Register);
  end

  // Forwarding bus mirrors the commit in the same cycle it is presented.
  always_comb begin
    fwd_valid = we;
    fwd_dest  = Write_Register;
    fwd_value = wb_value;
  end

  // Retire counter: one per committed write, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_count <= '0;
    end else if (we) begin
      retire_count <= retire_count + 32'd1;
    end
  end

  wb_regfile #(
    .NREGS (NREGS),
    .XLEN  (XLEN)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (Write_Register),
    .wdata   (wb_value),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage. Each cycle's stimulus pushes its
// hand-computed expectations into a queue tagged with the cycle number;
// a monitor on the falling edge pops and compares them.
module tb_wb_stage;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int K_RS     = 0;
  localparam int K_RT     = 1;
  localparam int K_FVALID = 2;
  localparam int K_FDEST  = 3;
  localparam int K_FVALUE = 4;
  localparam int K_RETIRE = 5;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  WB = 2'b00;
  logic [31:0] WB_Address = '0;
  logic [31:0] WB_Data = '0;
  logic [4:0]  Write_Register = '0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        fwd_valid;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_value;
  logic [31:0] retire_count;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  wb_stage dut (
    .clk            (clk),
    .rst            (rst),
    .WB             (WB),
    .WB_Address     (WB_Address),
    .WB_Data        (WB_Data),
    .Write_Register (Write_Register),
    .rs_addr        (rs_addr),
    .rt_addr        (rt_addr),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .fwd_valid      (fwd_valid),
    .fwd_dest       (fwd_dest),
    .fwd_value      (fwd_value),
    .retire_count   (retire_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kind_name(input int k);
    case (k)
      K_RS:     return "rs_data";
      K_RT:     return "rt_data";
      K_FVALID: return "fwd_valid";
      K_FDEST:  return "fwd_dest";
      K_FVALUE: return "fwd_value";
      default:  return "retire_count";
    endcase
  endfunction

  function automatic void expect_out(input int kind, input logic [31:0] exp);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.exp  = exp;
    sb.push_back(e);
  endfunction

  task automatic applyStimulus(input logic r, input logic [1:0] wb,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [4:0] wr, input logic [4:0] rs,
                               input logic [4:0] rt);
    @(posedge clk);
    #1;
    rst            = r;
    WB             = wb;
    WB_Address     = addr;
    WB_Data        = data;
    Write_Register = wr;
    rs_addr        = rs;
    rt_addr        = rt;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [31:0] act;
    case (e.kind)
      K_RS:     act = rs_data;
      K_RT:     act = rt_data;
      K_FVALID: act = {31'd0, fwd_valid};
      K_FDEST:  act = {27'd0, fwd_dest};
      K_FVALUE: act = fwd_value;
      default:  act = retire_count;
    endcase
    checks++;
    if (act !== e.exp) begin
      failures++;
      $display("[TB] FAIL cycle %0d %s: got 0x%08h expected 0x%08h",
               e.cyc, kind_name(e.kind), act, e.exp);
    end
  endtask

  // Monitor: compare every expectation registered for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      checkOutput(sb.pop_front());
    end
  end

  initial begin
    // Reset cycle: no commit requested.
    applyStimulus(1'b1, 2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    expect_out(K_FVALID, 32'd0);

    // Post-reset reads.
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd5, 5'd31);
    expect_out(K_RS, 32'h0);
    expect_out(K_RT, 32'h0);
    expect_out(K_RETIRE, 32'd0);
    expect_out(K_FVALID, 32'd0);

    // ALU write r7 = DEADBEEF, reading r7 in the same cycle.
    applyStimulus(1'b0, 2'b10, 32'hDEAD_BEEF, 32'h1111_1111, 5'd7, 5'd7, 5'd0);
    expect_out(K_FVALID, 32'd1);
    expect_out(K_FDEST, 32'd7);
    expect_out(K_FVALUE, 32'hDEAD_BEEF);
    expect_out(K_RS, BYP ? 32'hDEAD_BEEF : 32'h0);
    expect_out(K_RETIRE, 32'd0);

    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd7, 5'd0);
    expect_out(K_RS, 32'hDEAD_BEEF);
    expect_out(K_RETIRE, 32'd1);

    // Load write r3 = 12345678 (selects WB_Data over WB_Address).
    applyStimulus(1'b0, 2'b11, 32'h0000_0100, 32'h1234_5678, 5'd3, 5'd0, 5'd7);
    expect_out(K_FVALID, 32'd1);
    expect_out(K_FDEST, 32'd3);
    expect_out(K_FVALUE, 32'h1234_5678);
    expect_out(K_RT, 32'hDEAD_BEEF);
    expect_out(K_RS, 32'h0);

    // MemToReg without RegWrite: no write, no count.
    applyStimulus(1'b0, 2'b01, 32'h2, 32'hFFFF_0000, 5'd3, 5'd3, 5'd7);
    expect_out(K_RS, 32'h1234_5678);
    expect_out(K_RT, 32'hDEAD_BEEF);
    expect_out(K_FVALID, 32'd0);
    expect_out(K_RETIRE, 32'd2);

    // Write to r0 is discarded.
    applyStimulus(1'b0, 2'b11, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    expect_out(K_FVALID, 32'd0);
    expect_out(K_RS, 32'h0);
    expect_out(K_RETIRE, 32'd2);

    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd3);
    expect_out(K_RS, 32'h0);
    expect_out(K_RT, 32'h1234_5678);
    expect_out(K_RETIRE, 32'd2);

    // Same-cycle hazard on r9, both ports reading the same index.
    applyStimulus(1'b0, 2'b10, 32'hA5A5_A5A5, 32'h0, 5'd9, 5'd9, 5'd9);
    expect_out(K_RS, BYP ? 32'hA5A5_A5A5 : 32'h0);
    expect_out(K_RT, BYP ? 32'hA5A5_A5A5 : 32'h0);

    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9);
    expect_out(K_RS, 32'hA5A5_A5A5);
    expect_out(K_RT, 32'hA5A5_A5A5);
    expect_out(K_RETIRE, 32'd3);

    // Overwrite r3 while reading it.
    applyStimulus(1'b0, 2'b10, 32'h0000_CAFE, 32'h0, 5'd3, 5'd3, 5'd7);
    expect_out(K_RS, BYP ? 32'h0000_CAFE : 32'h1234_5678);

    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0);
    expect_out(K_RS, 32'h0000_CAFE);
    expect_out(K_RETIRE, 32'd4);

    // Reset mid-stream with an in-flight write to r4.
    applyStimulus(1'b1, 2'b10, 32'h0000_0055, 32'h0, 5'd4, 5'd4, 5'd0);
    expect_out(K_FVALID, 32'd1);
    expect_out(K_RETIRE, 32'd4);

    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd4, 5'd7);
    expect_out(K_RS, 32'h0);
    expect_out(K_RT, 32'h0);
    expect_out(K_RETIRE, 32'd0);

    // Normal operation resumes after reset.
    applyStimulus(1'b0, 2'b10, 32'h0000_0077, 32'h0, 5'd4, 5'd0, 5'd0);
    expect_out(K_FVALUE, 32'h0000_0077);

    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd4, 5'd9);
    expect_out(K_RS, 32'h0000_0077);
    expect_out(K_RT, 32'h0);
    expect_out(K_RETIRE, 32'd1);

    // Let the monitor drain, then make sure nothing was left unchecked.
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
